// File: rtl/dct_transpose_buf_if.sv
// Row-in / column-out stream bundle for the 8x8 DCT transpose buffer.
// The master side produces rows and consumes columns; the slave side is the buffer.
interface dct_transpose_buf_if #(
  parameter int unsigned BW = 11
);
  logic            in_valid;
  logic            in_ready;
  logic [8*BW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [8*BW-1:0] out_data;
  logic            out_last;
  logic [2:0]      out_col;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_last,
    input  out_col
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_last,
    output out_col
  );
endinterface

// File: rtl/dct_transpose_buf.sv
// Ping-pong 8x8 transpose buffer: rows are written into one bank while the
// other bank is read out column by column.
module dct_transpose_buf #(
  parameter int unsigned BW = 11
) (
  input logic                clk,
  input logic                reset,
  dct_transpose_buf_if.slave bus
);

  logic [BW-1:0]   r_mem [2][8][8];
  logic            r_wr_bank;
  logic            r_rd_bank;
  logic [2:0]      r_wr_row;
  logic [2:0]      r_rd_col;
  logic [1:0]      r_full;

  logic            w_wr_bank_nxt;
  logic            w_rd_bank_nxt;
  logic [2:0]      w_wr_row_nxt;
  logic [2:0]      w_rd_col_nxt;
  logic [1:0]      w_full_nxt;

  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_wr_fire;
  logic            w_rd_fire;
  logic [8*BW-1:0] w_out_data;

  // Handshakes are forced low while reset is asserted.
  assign w_in_ready  = reset & ~r_full[r_wr_bank];
  assign w_out_valid = reset & r_full[r_rd_bank];
  assign w_wr_fire   = bus.in_valid & w_in_ready;
  assign w_rd_fire   = w_out_valid & bus.out_ready;

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_last  = w_out_valid & (r_rd_col == 3'd7);
  assign bus.out_col   = reset ? r_rd_col : 3'd0;
  assign bus.out_data  = w_out_data;

  // Column read straight from the register array of the draining bank.
  always_comb begin
    w_out_data = '0;
    for (int k = 0; k < 8; k++) begin
      w_out_data[k*BW +: BW] = r_mem[r_rd_bank][3'(k)][r_rd_col];
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_fire) begin
      for (int k = 0; k < 8; k++) begin
        r_mem[r_wr_bank][r_wr_row][3'(k)] <= bus.in_data[k*BW +: BW];
      end
    end
  end

  // Write and read sides update their own full bit; they never target the same bank.
  always_comb begin
    w_wr_bank_nxt = r_wr_bank;
    w_rd_bank_nxt = r_rd_bank;
    w_wr_row_nxt  = r_wr_row;
    w_rd_col_nxt  = r_rd_col;
    w_full_nxt    = r_full;
    if (w_wr_fire) begin
      w_wr_row_nxt = r_wr_row + 3'd1;
      if (r_wr_row == 3'd7) begin
        w_full_nxt[r_wr_bank] = 1'b1;
        w_wr_bank_nxt         = ~r_wr_bank;
      end
    end
    if (w_rd_fire) begin
      w_rd_col_nxt = r_rd_col + 3'd1;
      if (r_rd_col == 3'd7) begin
        w_full_nxt[r_rd_bank] = 1'b0;
        w_rd_bank_nxt         = ~r_rd_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_row  <= 3'd0;
      r_rd_col  <= 3'd0;
      r_full    <= 2'b00;
    end else begin
      r_wr_bank <= w_wr_bank_nxt;
      r_rd_bank <= w_rd_bank_nxt;
      r_wr_row  <= w_wr_row_nxt;
      r_rd_col  <= w_rd_col_nxt;
      r_full    <= w_full_nxt;
    end
  end

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Randomised bench for dct_transpose_buf against a block-queue transpose model.
module tb_dct_transpose_buf;
  localparam int unsigned BW = 11;
  localparam int unsigned BLK = 64 * BW;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dct_transpose_buf_if #(.BW(BW)) vif ();

  dct_transpose_buf #(.BW(BW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (vif)
  );

  int n_checks = 0;
  int n_bad    = 0;

  // Model: completed blocks awaiting readout, plus the block being assembled.
  logic [BLK-1:0]  blk_q[$];
  logic [BLK-1:0]  part;
  int              wrow = 0;
  int              rcol = 0;
  int              n_in = 0;
  int              n_out = 0;
  int              mode = 0;
  logic [8*BW-1:0] cur_row;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [8*BW-1:0] gen_row(input int r);
    logic [8*BW-1:0] v;
    v = '0;
    for (int k = 0; k < 8; k++) begin
      case (mode)
        0:       v[k*BW +: BW] = BW'(r * 8 + k);
        1:       v[k*BW +: BW] = (((r + k) & 1) != 0) ? 11'h400 : 11'h3FF;
        default: v[k*BW +: BW] = BW'($urandom);
      endcase
    end
    return v;
  endfunction

  task automatic cycle(input bit iv, input bit ordy);
    logic [8*BW-1:0] exp_col;
    bit              fire_in;
    bit              fire_out;
    vif.in_valid  = iv;
    vif.in_data   = cur_row;
    vif.out_ready = ordy;
    @(negedge clk);
    if (!reset) begin
      check_eq("rst_in_ready", 128'(vif.in_ready), 128'(0));
      check_eq("rst_out_valid", 128'(vif.out_valid), 128'(0));
      check_eq("rst_out_last", 128'(vif.out_last), 128'(0));
      check_eq("rst_out_col", 128'(vif.out_col), 128'(0));
      blk_q.delete();
      wrow = 0;
      rcol = 0;
      cur_row = gen_row(0);
    end else begin
      check_eq("in_ready", 128'(vif.in_ready), 128'(blk_q.size() < 2));
      check_eq("out_valid", 128'(vif.out_valid), 128'(blk_q.size() > 0));
      fire_in  = iv && vif.in_ready;
      fire_out = ordy && vif.out_valid;
      if (blk_q.size() > 0) begin
        for (int k = 0; k < 8; k++) exp_col[k*BW +: BW] = blk_q[0][(k*8 + rcol)*BW +: BW];
        check_eq("out_data", 128'(vif.out_data), 128'(exp_col));
        check_eq("out_col", 128'(vif.out_col), 128'(rcol));
        check_eq("out_last", 128'(vif.out_last), 128'(rcol == 7));
      end
      if (fire_out && blk_q.size() > 0) begin
        n_out++;
        rcol++;
        if (rcol == 8) begin
          rcol = 0;
          void'(blk_q.pop_front());
        end
      end
      if (fire_in) begin
        for (int k = 0; k < 8; k++) part[(wrow*8 + k)*BW +: BW] = cur_row[k*BW +: BW];
        n_in++;
        wrow++;
        if (wrow == 8) begin
          blk_q.push_back(part);
          wrow = 0;
        end
        cur_row = gen_row(wrow);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max_cyc);
    for (int i = 0; i < max_cyc && blk_q.size() > 0; i++) cycle(1'b0, 1'b1);
  endtask

  int in0, out0;

  initial begin
    vif.in_valid  = 1'b0;
    vif.out_ready = 1'b0;
    vif.in_data   = '0;
    part          = '0;
    cur_row       = gen_row(0);
    reset = 1'b0;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    reset = 1'b1;

    // Single block, ramp pattern.
    mode = 0; cur_row = gen_row(0); in0 = n_in; out0 = n_out;
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1);
    check_eq("t1_rows", 128'(n_in - in0), 128'(8));
    check_eq("t1_cols", 128'(n_out - out0), 128'(8));

    // Four blocks back to back at full rate: no bubbles on either side.
    in0 = n_in; out0 = n_out;
    for (int i = 0; i < 40; i++) cycle((n_in - in0) < 32, 1'b1);
    check_eq("t2_rows", 128'(n_in - in0), 128'(32));
    check_eq("t2_cols", 128'(n_out - out0), 128'(32));

    // Reader stalled: only two blocks fit.
    in0 = n_in; out0 = n_out;
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0);
    check_eq("t3_accepted", 128'(n_in - in0), 128'(16));
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b1);
    drain(40);
    check_eq("t3_cols", 128'(n_out - out0), 128'(8 * ((n_in - in0) / 8)));
    check_eq("t3_empty", 128'(blk_q.size()), 128'(0));
    for (int i = 0; i < 8 && wrow != 0; i++) cycle(1'b1, 1'b1);
    drain(20);

    // Extreme values, sign bit must survive.
    mode = 1; cur_row = gen_row(wrow); in0 = n_in; out0 = n_out;
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b1);
    drain(30);
    check_eq("t4_cols", 128'(n_out - out0), 128'(16));

    // Partial block discarded by reset.
    mode = 0; cur_row = gen_row(wrow); out0 = n_out;
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1);
    reset = 1'b0;
    cycle(1'b1, 1'b1);
    reset = 1'b1;
    in0 = n_in;
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1);
    drain(20);
    check_eq("t5_rows", 128'(n_in - in0), 128'(8));
    check_eq("t5_cols", 128'(n_out - out0), 128'(8));

    // Random handshakes over 64 blocks.
    mode = 2; cur_row = gen_row(wrow); in0 = n_in; out0 = n_out;
    for (int i = 0; i < 6000 && (n_in - in0) < 512; i++) begin
      cycle(($urandom & 1) != 0, ($urandom & 1) != 0);
    end
    drain(200);
    check_eq("t6_rows", 128'(n_in - in0), 128'(512));
    check_eq("t6_cols", 128'(n_out - out0), 128'(512));
    check_eq("t6_empty", 128'(blk_q.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
